// File: rtl/wb_arbiter.sv
// wb_arbiter -- register-file write-port producer.
//
// Merges single-cycle ALU results with multi-cycle memory/CSR returns into
// one registered write (we/wa/wd). The ALU has absolute priority and never
// stalls; memory returns are accepted through a valid/ready handshake and
// buffered in an in-order FIFO of DEPTH entries.
//
// Optional build macro: WB_BYPASS_EN
//   When defined, a memory return accepted while the FIFO is empty and the
//   ALU is not writing goes straight to the output register (we one cycle
//   after acceptance) instead of being pushed.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   alu_valid/rd/data     ALU writeback request (rd==0 produces no write)
//   mem_valid/ready/rd/data  memory-return handshake (rd==0 is discarded)
//   we, wa, wd            registered register-file write
//   chk_rd, chk_pending   hazard query: a write to chk_rd is still in flight
module wb_arbiter #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [AWIDTH-1:0] alu_rd,
    input  logic [DWIDTH-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [AWIDTH-1:0] mem_rd,
    input  logic [DWIDTH-1:0] mem_data,
    output logic              we,
    output logic [AWIDTH-1:0] wa,
    output logic [DWIDTH-1:0] wd,
    input  logic [AWIDTH-1:0] chk_rd,
    output logic              chk_pending
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AWIDTH-1:0] rd_q   [DEPTH];
    logic [DWIDTH-1:0] data_q [DEPTH];
    logic [PW-1:0]     rptr;
    logic [PW-1:0]     wptr;
    logic [CW-1:0]     count;

    logic alu_win;
    logic accept;
    logic pop;
    logic push;
    logic bypass;
    logic fifo_hit;

    assign mem_ready = !rst && (count != FULL);

    always_comb begin
        alu_win = alu_valid && (alu_rd != '0);
        accept  = mem_valid && mem_ready;
        pop     = !alu_win && (count != '0);
`ifdef WB_BYPASS_EN
        bypass  = accept && (mem_rd != '0) && (count == '0) && !alu_win;
`else
        bypass  = 1'b0;
`endif
        // x0 returns are consumed by the handshake but never stored
        push    = accept && (mem_rd != '0) && !bypass;
    end

    // Valid entries are the count slots starting at rptr; the pointer sum
    // wraps naturally because DEPTH is a power of two.
    always_comb begin
        fifo_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count) && (rd_q[rptr + PW'(i)] == chk_rd))
                fifo_hit = 1'b1;
        end
        chk_pending = (chk_rd != '0) && (fifo_hit || (we && (wa == chk_rd)));
    end

    // FIFO storage carries no reset: contents are only observed through count.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wptr]   <= mem_rd;
            data_q[wptr] <= mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we <= 1'b0;
            wa <= '0;
            wd <= '0;
        end else if (alu_win) begin
            we <= 1'b1;
            wa <= alu_rd;
            wd <= alu_data;
        end else if (pop) begin
            we <= 1'b1;
            wa <= rd_q[rptr];
            wd <= data_q[rptr];
        end else if (bypass) begin
            we <= 1'b1;
            wa <= mem_rd;
            wd <= mem_data;
        end else begin
            we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter -- directed table-driven bench for wb_arbiter plus
// hand-written multi-cycle sequences (latency, streaming wrap, mid-run reset).
// Expectations follow the default build; the latency and streaming sequences
// also cover WB_BYPASS_EN when that macro is defined for the bench.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  chk_rd;
    logic        chk_pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(4), .DWIDTH(32), .AWIDTH(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .we          (we),
        .wa          (wa),
        .wd          (wd),
        .chk_rd      (chk_rd),
        .chk_pending (chk_pending)
    );

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic [4:0]  crd;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        rdy;
        logic        pend;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(int r, int av, int ard, logic [31:0] ad,
                                int mv, int mrd, logic [31:0] md, int crd,
                                int e_we, int e_wa, logic [31:0] e_wd,
                                int e_rdy, int e_pend);
        vec_t v;
        v.rst = 1'(r);   v.av = 1'(av);  v.ard = 5'(ard); v.ad = ad;
        v.mv  = 1'(mv);  v.mrd = 5'(mrd); v.md = md;      v.crd = 5'(crd);
        v.we  = 1'(e_we); v.wa = 5'(e_wa); v.wd = e_wd;
        v.rdy = 1'(e_rdy); v.pend = 1'(e_pend);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    endtask

    logic [36:0] expq[$];
    int          nwr;

    initial begin
        rst = 1'b1;
        idle_inputs();
        chk_rd = '0;

        //            rst av ard ad            mv mrd md     crd  we wa wd            rdy pend
        vecs[0]  = mk(1, 0, 0,  32'h0,         1, 3, 32'h1,   3,  0, 0, 32'h0,        0, 0);
        vecs[1]  = mk(1, 0, 0,  32'h0,         1, 3, 32'h1,   3,  0, 0, 32'h0,        0, 0);
        vecs[2]  = mk(0, 0, 0,  32'h0,         0, 0, 32'h0,   3,  0, 0, 32'h0,        1, 0);
        vecs[3]  = mk(0, 1, 5,  32'hDEADBEEF,  0, 0, 32'h0,   5,  1, 5, 32'hDEADBEEF, 1, 1);
        vecs[4]  = mk(0, 1, 0,  32'h11111111,  0, 0, 32'h0,   5,  0, 5, 32'hDEADBEEF, 1, 0);
        vecs[5]  = mk(0, 1, 10, 32'hA0,        1, 1, 32'h101, 1,  1, 10, 32'hA0,      1, 1);
        vecs[6]  = mk(0, 1, 11, 32'hA1,        1, 2, 32'h102, 2,  1, 11, 32'hA1,      1, 1);
        vecs[7]  = mk(0, 1, 12, 32'hA2,        1, 3, 32'h103, 3,  1, 12, 32'hA2,      1, 1);
        vecs[8]  = mk(0, 1, 13, 32'hA3,        1, 4, 32'h104, 4,  1, 13, 32'hA3,      0, 1);
        vecs[9]  = mk(0, 1, 14, 32'hA4,        1, 5, 32'h105, 5,  1, 14, 32'hA4,      0, 0);
        vecs[10] = mk(0, 1, 15, 32'hA5,        1, 5, 32'h105, 1,  1, 15, 32'hA5,      0, 1);
        vecs[11] = mk(0, 0, 0,  32'h0,         1, 5, 32'h105, 1,  1, 1, 32'h101,      1, 1);
        vecs[12] = mk(0, 0, 0,  32'h0,         0, 0, 32'h0,   1,  1, 2, 32'h102,      1, 0);
        vecs[13] = mk(0, 0, 0,  32'h0,         0, 0, 32'h0,   4,  1, 3, 32'h103,      1, 1);
        vecs[14] = mk(0, 0, 0,  32'h0,         0, 0, 32'h0,   4,  1, 4, 32'h104,      1, 1);
        vecs[15] = mk(0, 0, 0,  32'h0,         0, 0, 32'h0,   4,  0, 4, 32'h104,      1, 0);
        vecs[16] = mk(0, 0, 0,  32'h0,         1, 0, 32'h999, 0,  0, 4, 32'h104,      1, 0);
        vecs[17] = mk(0, 0, 0,  32'h0,         0, 0, 32'h0,   0,  0, 4, 32'h104,      1, 0);

        for (int i = 0; i < 18; i++) begin
            rst       = vecs[i].rst;
            alu_valid = vecs[i].av;
            alu_rd    = vecs[i].ard;
            alu_data  = vecs[i].ad;
            mem_valid = vecs[i].mv;
            mem_rd    = vecs[i].mrd;
            mem_data  = vecs[i].md;
            chk_rd    = vecs[i].crd;
            tick();
            chk($sformatf("v%0d we", i),    32'(we),          32'(vecs[i].we));
            chk($sformatf("v%0d wa", i),    32'(wa),          32'(vecs[i].wa));
            chk($sformatf("v%0d wd", i),    wd,               vecs[i].wd);
            chk($sformatf("v%0d ready", i), 32'(mem_ready),   32'(vecs[i].rdy));
            chk($sformatf("v%0d pend", i),  32'(chk_pending), 32'(vecs[i].pend));
        end

        // Memory latency with ALU idle
        idle_inputs();
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h12345678; chk_rd = 5'd7;
        tick();
        mem_valid = 1'b0;
`ifdef WB_BYPASS_EN
        chk("lat we1", 32'(we), 32'd1);
        chk("lat wa1", 32'(wa), 32'd7);
        chk("lat wd1", wd, 32'h12345678);
        chk("lat pend1", 32'(chk_pending), 32'd1);
        tick();
        chk("lat we2", 32'(we), 32'd0);
        chk("lat pend2", 32'(chk_pending), 32'd0);
`else
        chk("lat we1", 32'(we), 32'd0);
        chk("lat pend1", 32'(chk_pending), 32'd1);
        tick();
        chk("lat we2", 32'(we), 32'd1);
        chk("lat wa2", 32'(wa), 32'd7);
        chk("lat wd2", wd, 32'h12345678);
        chk("lat pend2", 32'(chk_pending), 32'd1);
        tick();
        chk("lat we3", 32'(we), 32'd0);
        chk("lat pend3", 32'(chk_pending), 32'd0);
`endif

        // Stream 10 returns back-to-back across pointer wrap
        nwr = 0;
        for (int k = 0; k < 16; k++) begin
            if (k < 10) begin
                mem_valid = 1'b1;
                mem_rd    = 5'(20 + k);
                mem_data  = 32'hC0000000 + 32'(k);
            end else begin
                mem_valid = 1'b0;
            end
            tick();
            if (k < 10) begin
                chk($sformatf("stream ready %0d", k), 32'(mem_ready), 32'd1);
                expq.push_back({5'(20 + k), 32'hC0000000 + 32'(k)});
            end
            if (we) begin
                if (expq.size() == 0) begin
                    chk("stream extra write", 32'(we), 32'd0);
                end else begin
                    chk($sformatf("stream wr%0d", nwr), {27'd0, wa} ^ wd, 
                        {27'd0, expq[0][36:32]} ^ expq[0][31:0]);
                    chk($sformatf("stream wa%0d", nwr), 32'(wa), 32'(expq[0][36:32]));
                    void'(expq.pop_front());
                    nwr++;
                end
            end
        end
        chk("stream count", 32'(nwr), 32'd10);
        chk("stream left", 32'(expq.size()), 32'd0);

        // Reset mid-operation discards buffered returns
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'(k);
            mem_valid = 1'b1; mem_rd = 5'(21 + k); mem_data = 32'hE0 + 32'(k);
            tick();
            chk($sformatf("rst load we%0d", k), 32'(we), 32'd1);
            chk($sformatf("rst load wa%0d", k), 32'(wa), 32'd9);
        end
        idle_inputs();
        chk_rd = 5'd22;
        #1;
        chk("rst pre pend22", 32'(chk_pending), 32'd1);
        rst = 1'b1;
        tick();
        chk("rst we", 32'(we), 32'd0);
        chk("rst wa", 32'(wa), 32'd0);
        chk("rst ready", 32'(mem_ready), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("post rst we%0d", k), 32'(we), 32'd0);
        end
        for (int r = 21; r < 24; r++) begin
            chk_rd = 5'(r);
            #1;
            chk($sformatf("post rst pend%0d", r), 32'(chk_pending), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Producer side of the register-file write port: merges single-cycle ALU results and multi-cycle memory/CSR returns into one registered write (we/wa/wd).
- The ALU source has absolute priority and never stalls. Memory returns enter through a valid/ready handshake and are buffered in an in-order FIFO.
- Exposes a pending-write query so the hazard unit can stall reads of registers whose writes are still in flight.

Parameters:
- DEPTH, 4, memory-return FIFO entries; power of two, >= 2.
- DWIDTH, 32, data width.
- AWIDTH, 5, register address width.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- alu_valid  input  1  ALU writeback request this cycle.
- alu_rd  input  AWIDTH  ALU destination register.
- alu_data  input  DWIDTH  ALU result.
- mem_valid  input  1  memory return valid.
- mem_ready  output  1  FIFO can accept a memory return.
- mem_rd  input  AWIDTH  memory-return destination register.
- mem_data  input  DWIDTH  memory-return data.
- we  output  1  register-file write enable (registered).
- wa  output  AWIDTH  register-file write address (registered).
- wd  output  DWIDTH  register-file write data (registered).
- chk_rd  input  AWIDTH  register to query.
- chk_pending  output  1  a write to chk_rd is buffered or in the output stage.

Behaviour:
- Reset (rst high at clk edge):
  - we=0, wa=0, wd=0.
  - FIFO emptied: read/write pointers and count all 0.
  - mem_ready=0 while rst is high; it rises the first cycle after rst deasserts.
  - Reset mid-operation discards all buffered returns; no write is issued for them.
- Handshake:
  - A memory return is accepted when mem_valid && mem_ready at the clk edge.
  - mem_ready = !rst && (count != DEPTH); it depends only on registered count.
  - When full, no push occurs even if a pop happens in the same cycle.
  - mem_valid/mem_rd/mem_data may change freely while mem_ready=0.
- x0 filtering:
  - An accepted return with mem_rd==0 is consumed and discarded; it is not pushed.
  - alu_valid with alu_rd==0 produces no write (we=0 next cycle).
- Arbitration, evaluated each cycle with the registered result visible next cycle:
  - alu_valid && alu_rd!=0: next we=1, wa=alu_rd, wd=alu_data; the FIFO head is held.
  - Otherwise, FIFO non-empty: pop the head; next we=1, wa/wd = head entry.
  - Otherwise: next we=0; wa/wd hold their previous values.
- Latency (macro off):
  - ALU request at cycle N -> we at N+1.
  - Memory accept at N -> earliest we at N+2, in FIFO order.
- Simultaneous push and pop on a non-full FIFO: both occur and count is unchanged. Pointers wrap modulo DEPTH.
- Ordering:
  - Memory returns commit in acceptance order.
  - No ordering is enforced between ALU and memory writes to the same rd; the hazard unit uses chk_pending.
- chk_pending is combinational: chk_rd!=0 && (any valid FIFO entry has rd==chk_rd, || (we && wa==chk_rd)).
- Counts use AWIDTH-independent log2(DEPTH)+1 bits; no overflow is possible given the full check.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when the FIFO is empty, alu_valid is low (or alu_rd==0), and a memory return with mem_rd!=0 is accepted, that return goes directly to the output register (we at N+1) and is not pushed.
- Not defined: every memory return passes through the FIFO, with minimum latency 2 cycles.
- ALU priority and reset behaviour are identical in both builds.

Test Plan:
- Reset: hold rst 2 cycles with mem_valid=1 -> we=0, mem_ready=0 during reset, mem_ready=1 the cycle after, no push.
- ALU only: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF at N -> we=1, wa=5, wd=0xDEADBEEF at N+1. Same request with alu_rd=0 -> we=0.
- Memory latency: accept rd=7, data=0x12345678 at N with ALU idle -> write at N+2 (macro off) or N+1 (WB_BYPASS_EN); chk_rd=7 gives chk_pending=1 until that write is in the regfile.
- Priority/fill: alu_valid=1 for 6 cycles while offering returns rd=1..6 -> 4 accepted, mem_ready=0 after the 4th, then rd=1..4 written in order after ALU stops, ready reasserts after the first pop.
- Wrap and simultaneous push/pop: stream 10 returns with ALU idle at 1/cycle -> count stays constant, all 10 written in order with correct data across pointer wrap.
- Reset mid-operation: 3 buffered entries, assert rst -> none written afterwards, chk_pending=0 for their rds.
